two_phase_monitor: RTL

//   Receive-side checker for the non-overlapping two-phase clock pair (phi1/phi2).

---
 rtl/two_phase_monitor_if.sv | 28 ++
 rtl/two_phase_monitor.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/two_phase_monitor_if.sv
// Signal bundle between the two-phase clock source side and the phi1/phi2 monitor.
// The master drives the phase pair and error clear; the slave returns tracker status.
interface two_phase_monitor_if #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
);
    logic             phi1_i;
    logic             phi2_i;
    logic             clr_err_i;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] cycle_cnt_o;
    logic             seq_err_o;
    logic             ovl_err_o;
    logic             err_o;
    logic [ERR_W-1:0] err_cnt_o;
    logic             stall_o;
    logic             locked_o;

    modport master (
        output phi1_i, phi2_i, clr_err_i,
        input  state_o, cycle_cnt_o, seq_err_o, ovl_err_o, err_o, err_cnt_o, stall_o, locked_o
    );

    modport slave (
        input  phi1_i, phi2_i, clr_err_i,
        output state_o, cycle_cnt_o, seq_err_o, ovl_err_o, err_o, err_cnt_o, stall_o, locked_o
    );
endinterface

// File: rtl/two_phase_monitor.sv
// Receive-side checker for a non-overlapping phi1/phi2 pair: tracks the 10,00,01,00
// sequence, counts completed cycles, flags overlap/order errors and stalls, reports lock.
//
// state | meaning
// IDLE  | waiting for phi1 to rise (pair 00)
// P1    | phi1 high (pair 10)
// G1    | gap after phi1 (pair 00)
// P2    | phi2 high (pair 01)
// G2    | gap after phi2, cycle complete (pair 00)
module two_phase_monitor #(
    parameter int CNT_W       = 16,
    parameter int ERR_W       = 8,
    parameter int STALL_MAX   = 8,
    parameter int LOCK_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 clear_i,
    two_phase_monitor_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        G1   = 3'd2,
        P2   = 3'd3,
        G2   = 3'd4
    } state_t;

    localparam int HOLD_W  = $clog2(STALL_MAX + 1);
    localparam int CLEAN_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LIM  = HOLD_W'(STALL_MAX);
    localparam logic [CLEAN_W-1:0] CLEAN_LIM = CLEAN_W'(LOCK_CYCLES);
    localparam logic [ERR_W-1:0]   ERR_MAX   = {ERR_W{1'b1}};

    state_t             state;
    state_t             state_nxt;
    logic [HOLD_W-1:0]  hold;
    logic [HOLD_W-1:0]  hold_nxt;
    logic [CLEAN_W-1:0] clean;
    logic [CLEAN_W-1:0] clean_nxt;
    logic [CNT_W-1:0]   cycle_cnt;
    logic [ERR_W-1:0]   err_cnt;
    logic [ERR_W-1:0]   err_cnt_nxt;
    logic [1:0]         pair;
    logic               seq;
    logic               ovl;
    logic               err_any;
    logic               done;
    logic               stall_nxt;
    logic               seq_err;
    logic               ovl_err;
    logic               err;
    logic               stall;
    logic               locked;

    always_comb begin
        pair      = {bus.phi1_i, bus.phi2_i};
        state_nxt = state;
        seq       = 1'b0;
        ovl       = 1'b0;
        if (pair == 2'b11) begin
            ovl       = 1'b1;
            state_nxt = IDLE;
        end else begin
            // Each state accepts its own pair (stay) or its successor's pair; anything else is out of order.
            case (state)
                IDLE: case (pair)
                    2'b10:   state_nxt = P1;
                    2'b01:   seq = 1'b1;
                    default: state_nxt = IDLE;
                endcase
                P1: case (pair)
                    2'b00:   state_nxt = G1;
                    2'b01:   begin seq = 1'b1; state_nxt = IDLE; end
                    default: state_nxt = P1;
                endcase
                G1: case (pair)
                    2'b01:   state_nxt = P2;
                    2'b10:   begin seq = 1'b1; state_nxt = IDLE; end
                    default: state_nxt = G1;
                endcase
                P2: case (pair)
                    2'b00:   state_nxt = G2;
                    2'b10:   begin seq = 1'b1; state_nxt = IDLE; end
                    default: state_nxt = P2;
                endcase
                G2: case (pair)
                    2'b10:   state_nxt = P1;
                    2'b01:   begin seq = 1'b1; state_nxt = IDLE; end
                    default: state_nxt = G2;
                endcase
                default: state_nxt = IDLE;
            endcase
        end

        err_any = seq | ovl;
        done    = (state == P2) && (state_nxt == G2);

        if ((state_nxt == state) && (state != IDLE))
            hold_nxt = (hold == HOLD_LIM) ? hold : hold + HOLD_W'(1);
        else
            hold_nxt = '0;
        stall_nxt = (hold_nxt >= HOLD_LIM);

        if (err_any || stall_nxt)
            clean_nxt = '0;
        else if (done && (clean != CLEAN_LIM))
            clean_nxt = clean + CLEAN_W'(1);
        else
            clean_nxt = clean;

        // A new error in the same cycle as a clear counts as the first error after the clear.
        if (err_any)
            err_cnt_nxt = bus.clr_err_i ? ERR_W'(1)
                        : ((err_cnt == ERR_MAX) ? err_cnt : err_cnt + ERR_W'(1));
        else if (bus.clr_err_i)
            err_cnt_nxt = '0;
        else
            err_cnt_nxt = err_cnt;
    end

    always_ff @(posedge clk_i) begin
        if (!clear_i) begin
            state     <= IDLE;
            hold      <= '0;
            clean     <= '0;
            cycle_cnt <= '0;
            err_cnt   <= '0;
            seq_err   <= 1'b0;
            ovl_err   <= 1'b0;
            err       <= 1'b0;
            stall     <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold      <= hold_nxt;
            clean     <= clean_nxt;
            cycle_cnt <= done ? cycle_cnt + CNT_W'(1) : cycle_cnt;
            err_cnt   <= err_cnt_nxt;
            seq_err   <= seq;
            ovl_err   <= ovl;
            err       <= err_any | (err & ~bus.clr_err_i);
            stall     <= stall_nxt;
            locked    <= (clean_nxt == CLEAN_LIM);
        end
    end

    assign bus.state_o     = state;
    assign bus.cycle_cnt_o = cycle_cnt;
    assign bus.seq_err_o   = seq_err;
    assign bus.ovl_err_o   = ovl_err;
    assign bus.err_o       = err;
    assign bus.err_cnt_o   = err_cnt;
    assign bus.stall_o     = stall;
    assign bus.locked_o    = locked;
endmodule
